// File: rtl/axi_ram_rd_backend_if.sv
//==============================================================================
// Module      : axi_ram_rd_backend_if
// Description : RAM read command / response stream between the AXI RAM read
//               front end (master) and the memory back end (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface axi_ram_rd_backend_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int ID_WIDTH    = 8,
    parameter int RUSER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]    ram_rd_cmd_id;
    logic [ADDR_WIDTH-1:0]  ram_rd_cmd_addr;
    logic                   ram_rd_cmd_en;
    logic                   ram_rd_cmd_last;
    logic                   ram_rd_cmd_ready;
    logic [ID_WIDTH-1:0]    ram_rd_resp_id;
    logic [DATA_WIDTH-1:0]  ram_rd_resp_data;
    logic                   ram_rd_resp_last;
    logic [RUSER_WIDTH-1:0] ram_rd_resp_user;
    logic                   ram_rd_resp_valid;
    logic                   ram_rd_resp_ready;

    modport master (
        output ram_rd_cmd_id, ram_rd_cmd_addr, ram_rd_cmd_en, ram_rd_cmd_last,
        input  ram_rd_cmd_ready,
        input  ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last,
        input  ram_rd_resp_user, ram_rd_resp_valid,
        output ram_rd_resp_ready
    );

    modport slave (
        input  ram_rd_cmd_id, ram_rd_cmd_addr, ram_rd_cmd_en, ram_rd_cmd_last,
        output ram_rd_cmd_ready,
        output ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last,
        output ram_rd_resp_user, ram_rd_resp_valid,
        input  ram_rd_resp_ready
    );
endinterface

`default_nettype wire

// File: rtl/axi_ram_rd_backend.sv
//==============================================================================
// Module      : axi_ram_rd_backend
// Description : Word RAM with one-cycle read stage and credit-checked output
//               FIFO serving the RAM read command stream. Optional performance
//               counters enabled by AXI_RAM_RD_BACKEND_PERF_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_ram_rd_backend #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int RUSER_WIDTH = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    axi_ram_rd_backend_if.slave        rd_if,
    input  wire logic                  mem_wr_en,
    input  wire logic [ADDR_WIDTH-1:0] mem_wr_addr,
    input  wire logic [DATA_WIDTH-1:0] mem_wr_data,
    input  wire logic [STRB_WIDTH-1:0] mem_wr_strb
`ifdef AXI_RAM_RD_BACKEND_PERF_CNT_EN
    ,
    output logic [31:0]                perf_beat_count,
    output logic [31:0]                perf_stall_count
`endif
);

    localparam int SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W = ADDR_WIDTH - SHIFT;
    localparam int WORDS = 2 ** IDX_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    logic                  rst_done_q;
    logic                  rd_valid_q;
    logic [ID_WIDTH-1:0]   rd_id_q;
    logic                  rd_last_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id_q   [FIFO_DEPTH];
    logic                  fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q;
    logic [PTR_W-1:0]      rptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    logic                  cmd_ready;
    logic                  cmd_accept;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      credits_used;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;

    assign rd_idx = rd_if.ram_rd_cmd_addr[ADDR_WIDTH-1:SHIFT];
    assign wr_idx = mem_wr_addr[ADDR_WIDTH-1:SHIFT];

    generate
        if (SHIFT > 0) begin : g_addr_lsb
            logic unused_addr_lsb;
            assign unused_addr_lsb = ^{rd_if.ram_rd_cmd_addr[SHIFT-1:0],
                                       mem_wr_addr[SHIFT-1:0]};
        end
    endgenerate

    // The read stage counts as a credit so its unconditional push always fits.
    assign credits_used = count_q + CNT_W'(rd_valid_q);
    assign cmd_ready    = rst_done_q && (credits_used < CNT_W'(FIFO_DEPTH));
    assign cmd_accept   = rd_if.ram_rd_cmd_en && cmd_ready;
    assign fifo_empty   = (count_q == '0);
    assign fifo_push    = rd_valid_q;
    assign fifo_pop     = !fifo_empty && rd_if.ram_rd_resp_ready;

    always_comb begin
        count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end

    // Array and read data are not reset; nonblocking update gives read-first.
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (mem_wr_strb[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
                end
            end
        end
        if (cmd_accept) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data_q[wptr_q] <= rd_data_q;
            fifo_id_q[wptr_q]   <= rd_id_q;
            fifo_last_q[wptr_q] <= rd_last_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_done_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            rd_last_q  <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            rst_done_q <= 1'b1;
            rd_valid_q <= cmd_accept;
            if (cmd_accept) begin
                rd_id_q   <= rd_if.ram_rd_cmd_id;
                rd_last_q <= rd_if.ram_rd_cmd_last;
            end
            if (fifo_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign rd_if.ram_rd_cmd_ready  = cmd_ready;
    assign rd_if.ram_rd_resp_valid = !fifo_empty;
    assign rd_if.ram_rd_resp_data  = fifo_empty ? '0 : fifo_data_q[rptr_q];
    assign rd_if.ram_rd_resp_id    = fifo_empty ? '0 : fifo_id_q[rptr_q];
    assign rd_if.ram_rd_resp_last  = fifo_empty ? 1'b0 : fifo_last_q[rptr_q];
    assign rd_if.ram_rd_resp_user  = '0;

`ifdef AXI_RAM_RD_BACKEND_PERF_CNT_EN
    logic [31:0] beat_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fifo_pop) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
            if (rd_if.ram_rd_cmd_en && !cmd_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_beat_count  = beat_cnt_q;
    assign perf_stall_count = stall_cnt_q;
`endif

endmodule

`default_nettype wire
